// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single write port of the 32x32 register file between the
//   in-order pipeline writeback stage (always highest priority) and a
//   multi-cycle result source. Multi-cycle results wait in a small FIFO.
//   Live FIFO entries are published as a busy mask for the hazard unit.
//   A FIFO head that has been blocked for too long raises a stall request.
//   Outputs are registered at posedge. The register file captures them on
//   the following negedge.
//
// Ports
//   clk, rst_n            clock (posedge), asynchronous active-low reset
//   wb_we/wb_addr/wb_data pipeline writeback request (wb_addr 0 = no request)
//   mc_valid/mc_addr/     multi-cycle result offer; mc_ready = FIFO not full
//   mc_data/mc_ready
//   wreg/writeReg/regData registered register-file write port
//   busy                  bit r set while a live FIFO entry targets register r
//   stall_req             registered request to freeze the pipeline
//   protocol_err          sticky: wb_we seen while stall_req was high
module regfile_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [4:0]        mc_addr,
  input  logic [DATA_W-1:0] mc_data,
  output logic              wreg,
  output logic [4:0]        writeReg,
  output logic [DATA_W-1:0] regData,
  output logic [31:0]       busy,
  output logic              stall_req,
  output logic              protocol_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= 4'(MAX_WAIT)) ? 4'(MAX_WAIT) : v + 4'd1;
  endfunction

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  occ_q, occ_d;
  logic [DEPTH-1:0]  killed_q, killed_d;
  logic [4:0]        addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [3:0]        wait_q, wait_d;
  logic              stall_q, stall_d;
  logic              perr_q, perr_d;

  logic              vld_p0, vld_p1;
  logic [4:0]        waddr_p0, waddr_p1;
  logic [DATA_W-1:0] wdata_p0, wdata_p1;

  logic wb_req, fifo_full, fifo_empty, accept, pop, bypass, enq, head_live;
  logic [31:0] busy_v;

  // ---- stage p0: grant decision and FIFO next state ----
  always_comb begin
    fifo_full  = (count_q == CNT_W'(DEPTH));
    fifo_empty = (count_q == '0);
    wb_req     = wb_we && (wb_addr != 5'd0);
    accept     = mc_valid && !fifo_full;
    pop        = !wb_req && !fifo_empty;
    bypass     = !wb_req && fifo_empty && accept && (mc_addr != 5'd0);
    // zero-address results are accepted and silently dropped
    enq        = accept && (mc_addr != 5'd0) && !bypass;
    head_live  = !killed_q[rd_ptr_q];
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    occ_d    = occ_q;
    killed_d = killed_q;
    // a granted pipeline write supersedes every older queued write to that register
    if (wb_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occ_q[i] && (addr_q[i] == wb_addr)) killed_d[i] = 1'b1;
      end
    end
    if (pop) begin
      occ_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = next_ptr(rd_ptr_q);
    end
    // a same-cycle enqueue is newer than the pipeline write, so it stays live
    if (enq) begin
      occ_d[wr_ptr_q]    = 1'b1;
      killed_d[wr_ptr_q] = 1'b0;
      wr_ptr_d           = next_ptr(wr_ptr_q);
    end
    if (enq && !pop)      count_d = count_q + CNT_W'(1);
    else if (!enq && pop) count_d = count_q - CNT_W'(1);

    wait_d  = (pop || fifo_empty) ? 4'd0 : sat_inc(wait_q);
    stall_d = !pop && (wait_q == 4'(MAX_WAIT));
    perr_d  = perr_q || (wb_we && stall_q);
  end

  always_comb begin
    vld_p0   = 1'b0;
    waddr_p0 = waddr_p1;
    wdata_p0 = wdata_p1;
    if (wb_req) begin
      vld_p0   = 1'b1;
      waddr_p0 = wb_addr;
      wdata_p0 = wb_data;
    end else if (pop) begin
      // a killed head is still popped but produces no write
      if (head_live) begin
        vld_p0   = 1'b1;
        waddr_p0 = addr_q[rd_ptr_q];
        wdata_p0 = data_q[rd_ptr_q];
      end
    end else if (bypass) begin
      vld_p0   = 1'b1;
      waddr_p0 = mc_addr;
      wdata_p0 = mc_data;
    end
  end

  always_comb begin
    busy_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ_q[i] && !killed_q[i]) busy_v[addr_q[i]] = 1'b1;
    end
    busy_v[0] = 1'b0;
  end

  // ---- stage p1: registered write port and control state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      occ_q    <= '0;
      killed_q <= '0;
      wait_q   <= '0;
      stall_q  <= 1'b0;
      perr_q   <= 1'b0;
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      occ_q    <= occ_d;
      killed_q <= killed_d;
      wait_q   <= wait_d;
      stall_q  <= stall_d;
      perr_q   <= perr_d;
      vld_p1   <= vld_p0;
      waddr_p1 <= waddr_p0;
      wdata_p1 <= wdata_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr_q] <= mc_addr;
      data_q[wr_ptr_q] <= mc_data;
    end
  end

  assign mc_ready     = !fifo_full;
  assign busy         = busy_v;
  assign wreg         = vld_p1;
  assign writeReg     = waddr_p1;
  assign regData      = wdata_p1;
  assign stall_req    = stall_q;
  assign protocol_err = perr_q;

endmodule
